// File: rtl/pc_branch_unit.sv
// Fetch-side next-PC stage: holds the PC and picks the sequential, branch, jump or register target.
// Any redirect target that is misaligned or outside instruction memory locks the unit in a sticky fault.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        cmp_eq,
  input  logic        cmp_ne,
  input  logic        cmp_lt,
  input  logic        cmp_le,
  input  logic        cmp_gt,
  input  logic        cmp_ge,
  input  logic        cmp_t,
  input  logic [2:0]  br_cond,
  input  logic        is_branch,
  input  logic [15:0] imm16,
  input  logic        is_jump,
  input  logic [25:0] instr_index,
  input  logic        is_jr,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] link_addr,
  output logic        taken,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam logic [31:0] MEM_END = RESET_PC + 32'(IM_WORDS * 4);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic        cond;
  logic        redirect;
  logic        target_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      state_q      <= RUN;
      fault_addr_q <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      state_q      <= state_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    j_target  = {pc_plus4[31:28], instr_index, 2'b00};

    case (br_cond)
      3'd0:    cond = cmp_eq;
      3'd1:    cond = cmp_ne;
      3'd2:    cond = cmp_lt;
      3'd3:    cond = cmp_le;
      3'd4:    cond = cmp_gt;
      3'd5:    cond = cmp_ge;
      3'd6:    cond = cmp_t;
      default: cond = 1'b0;
    endcase

    redirect = is_jr | is_jump | (is_branch & cond);

    if (is_jr)                  target = rs_val;
    else if (is_jump)           target = j_target;
    else if (is_branch && cond) target = br_target;
    else                        target = pc_plus4;

    // Sequential fall-through off the end of memory is deliberately not checked.
    target_bad = redirect && ((target[1:0] != 2'b00) ||
                              (target < RESET_PC) ||
                              (target >= MEM_END));

    pc_d         = pc_q;
    state_d      = state_q;
    fault_addr_d = fault_addr_q;
    if (state_q == RUN && en) begin
      if (target_bad) begin
        state_d      = FAULT;
        fault_addr_d = target;
      end else begin
        pc_d = target;
      end
    end
  end

  assign pc         = pc_q;
  assign link_addr  = pc_plus4;
  assign taken      = redirect && (state_q == RUN);
  assign fault      = (state_q == FAULT);
  assign fault_addr = fault_addr_q;

endmodule
